lut_neuron_loader: RTL

Runtime-programmable counterpart to the generated fixed-ROM LUT neurons. It accepts a neuron's 2^IN_BITS-entry, 1-bit truth table over a valid/ready configuration stream and stores it in a register array. Once loaded, it answers registered lookups, so a layer's neurons can be reloaded in the field instead of re-synthesised.

---
 rtl/lut_neuron_loader.sv | 118 +++++++++++
 1 files changed

// File: rtl/lut_neuron_loader.sv
// Runtime-loadable single-output LUT neuron: a truth table streamed in over a
// valid/ready config port, then answered with registered one-cycle lookups.
module lut_neuron_loader #(
    parameter int IN_BITS = 8,
    parameter int CFG_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_start,
    input  logic [CFG_W-1:0]   cfg_data,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    output logic               cfg_done,
    output logic               loaded,
    input  logic [IN_BITS-1:0] in_data,
    input  logic               in_valid,
    output logic               out_data,
    output logic               out_valid
);
    localparam int DEPTH  = 1 << IN_BITS;
    localparam int NWORDS = DEPTH / CFG_W;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DEPTH-1:0]   table_q, table_d;
    logic               loaded_q, loaded_d;
    logic               cfg_done_q, cfg_done_d;
    logic               out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;

    // Handshake: a config word transfers on a rising edge where cfg_valid and
    // cfg_ready are both high; cfg_ready depends on the registered state only.
    assign cfg_ready = (state_q == LOAD);
    assign cfg_done  = cfg_done_q;
    assign loaded    = loaded_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        table_d    = table_q;
        loaded_d   = loaded_q;
        cfg_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                // A restart outranks a word accepted in the same cycle.
                if (cfg_start) begin
                    cnt_d = '0;
                end else if (cfg_valid) begin
                    table_d[int'(cnt_q) * CFG_W +: CFG_W] = cfg_data;
                    if (cnt_q == LAST_WORD) begin
                        state_d    = RUN;
                        cnt_d      = '0;
                        loaded_d   = 1'b1;
                        cfg_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RUN: begin
                if (cfg_start) begin
                    state_d  = LOAD;
                    cnt_d    = '0;
                    loaded_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                loaded_d = 1'b0;
            end
        endcase
    end

    // Stale entries left over from an earlier table are masked until loaded rises.
    always_comb begin
        out_valid_d = in_valid;
        out_data_d  = in_valid & loaded_q & table_q[in_data];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            table_q     <= '0;
            loaded_q    <= 1'b0;
            cfg_done_q  <= 1'b0;
            out_data_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            table_q     <= table_d;
            loaded_q    <= loaded_d;
            cfg_done_q  <= cfg_done_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
